// File: rtl/memoria_pkg.sv
// Shared types and constants for the parametrised data/program memory.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package memoria_pkg;

  // Init sequencer states: clear every word, write the two boot words, then serve requests.
  typedef enum logic [1:0] {
    LIMPIANDO = 2'd0,
    CARGANDO0 = 2'd1,
    CARGANDO1 = 2'd2,
    LISTO     = 2'd3
  } estado_t;

  // Default boot program: load immediate 23 into register 0.
  localparam logic [15:0] ARRANQUE0_DEF = 16'h4000;
  localparam logic [15:0] ARRANQUE1_DEF = 16'h0017;

  // Bits needed to index 'profundidad' words; never less than one bit.
  function automatic int ancho_puntero(input int profundidad);
    int ancho;
    ancho = $clog2(profundidad);
    return (ancho < 1) ? 1 : ancho;
  endfunction

endpackage

// File: rtl/memoria_nucleo.sv
// Plain single-port storage array: one write port, one registered read port, no reset.
// Latency: write commits at the edge; read data appears one edge after re_i.
// Backpressure: none; the caller gates every access and keeps addresses in range.
module memoria_nucleo
  import memoria_pkg::*;
#(
  parameter int ANCHO_DATOS = 16,
  parameter int PROFUNDIDAD = 16,
  parameter int AP          = ancho_puntero(PROFUNDIDAD)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [AP-1:0]          waddr_i,
  input  logic [ANCHO_DATOS-1:0] wdat_i,
  input  logic                   re_i,
  input  logic [AP-1:0]          raddr_i,
  output logic [ANCHO_DATOS-1:0] rdat_o
);

  logic [ANCHO_DATOS-1:0] mem_q [PROFUNDIDAD];
  logic [ANCHO_DATOS-1:0] rdat_q;

  // Write port: contents survive reset on purpose, the sequencer rewrites them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdat_i;
    end
  end

  // Read port: the output register only moves on a read, so it holds between reads.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdat_q <= mem_q[raddr_i];
    end
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/memoria_parametrizada.sv
// Parametrised single-port memory with a clear-and-boot sequencer and range-checked access.
// Latency: reads return one edge after the request; writes commit at the request edge.
// Backpressure: Ocupado high during init; requests made then are silently dropped.
module memoria_parametrizada
  import memoria_pkg::*;
#(
  parameter int          ANCHO_DATOS     = 16,
  parameter int          PROFUNDIDAD     = 16,
  parameter int          ANCHO_DIRECCION = 16,
  parameter logic [15:0] ARRANQUE0       = ARRANQUE0_DEF,
  parameter logic [15:0] ARRANQUE1       = ARRANQUE1_DEF
) (
  input  logic                       Reloj,
  input  logic                       Reinicio,
  input  logic [ANCHO_DATOS-1:0]     Entrada,
  input  logic [ANCHO_DIRECCION-1:0] Direccion,
  input  logic                       HabilitarEscritura,
  input  logic                       HabilitarSalida,
  output logic [ANCHO_DATOS-1:0]     Salida,
  output logic                       SalidaValida,
  output logic                       Ocupado,
  output logic                       ErrorDireccion
);

  localparam int AP = ancho_puntero(PROFUNDIDAD);
  localparam logic [AP-1:0]              ULTIMO    = AP'(PROFUNDIDAD - 1);
  localparam logic [ANCHO_DIRECCION:0]   PROF_EXT  = (ANCHO_DIRECCION + 1)'(PROFUNDIDAD);
  localparam logic [ANCHO_DATOS-1:0]     BOOT0     = ANCHO_DATOS'(ARRANQUE0);
  localparam logic [ANCHO_DATOS-1:0]     BOOT1     = ANCHO_DATOS'(ARRANQUE1);

  estado_t                estado_q, estado_d;
  logic [AP-1:0]          puntero_q, puntero_d;
  logic                   valida_q, valida_d;
  logic                   error_q, error_d;
  // When set, Salida is forced to zero (after reset and after an out-of-range read).
  logic                   cero_q, cero_d;

  logic                   mem_we, mem_re;
  logic [AP-1:0]          mem_waddr;
  logic [ANCHO_DATOS-1:0] mem_wdat;
  logic [ANCHO_DATOS-1:0] mem_rdat;
  logic                   en_rango;
  logic [AP-1:0]          dir_corta;

  // Full-width compare, one extra bit so a depth of 2**ANCHO_DIRECCION still fits.
  assign en_rango  = ({1'b0, Direccion} < PROF_EXT);
  assign dir_corta = Direccion[AP-1:0];

  // Next state, write-port arbitration between sequencer and user, and strobes.
  always_comb begin
    estado_d  = estado_q;
    puntero_d = puntero_q;
    valida_d  = 1'b0;
    error_d   = 1'b0;
    cero_d    = cero_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = puntero_q;
    mem_wdat  = '0;
    case (estado_q)
      LIMPIANDO: begin
        mem_we    = 1'b1;
        puntero_d = puntero_q + AP'(1);
        if (puntero_q == ULTIMO) begin
          puntero_d = '0;
          estado_d  = CARGANDO0;
        end
      end
      CARGANDO0: begin
        mem_we    = 1'b1;
        mem_waddr = '0;
        mem_wdat  = BOOT0;
        estado_d  = CARGANDO1;
      end
      CARGANDO1: begin
        mem_we    = 1'b1;
        mem_waddr = AP'(1);
        mem_wdat  = BOOT1;
        estado_d  = LISTO;
      end
      LISTO: begin
        mem_waddr = dir_corta;
        mem_wdat  = Entrada;
        if (HabilitarEscritura) begin
          // A write always wins; any simultaneous read is dropped.
          mem_we  = en_rango;
          error_d = !en_rango;
        end else if (HabilitarSalida) begin
          mem_re   = en_rango;
          valida_d = 1'b1;
          error_d  = !en_rango;
          cero_d   = !en_rango;
        end
      end
      default: begin
        estado_d  = LIMPIANDO;
        puntero_d = '0;
      end
    endcase
    // Nothing touches the array on a reset edge; the rerun sequence owns it.
    if (Reinicio) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  // State, clear pointer and output strobes, with synchronous reset back to clearing.
  always_ff @(posedge Reloj) begin
    if (Reinicio) begin
      estado_q  <= LIMPIANDO;
      puntero_q <= '0;
      valida_q  <= 1'b0;
      error_q   <= 1'b0;
      cero_q    <= 1'b1;
    end else begin
      estado_q  <= estado_d;
      puntero_q <= puntero_d;
      valida_q  <= valida_d;
      error_q   <= error_d;
      cero_q    <= cero_d;
    end
  end

  memoria_nucleo #(
    .ANCHO_DATOS (ANCHO_DATOS),
    .PROFUNDIDAD (PROFUNDIDAD),
    .AP          (AP)
  ) u_nucleo (
    .clk_i   (Reloj),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdat_i  (mem_wdat),
    .re_i    (mem_re),
    .raddr_i (dir_corta),
    .rdat_o  (mem_rdat)
  );

  assign Salida         = cero_q ? '0 : mem_rdat;
  assign SalidaValida   = valida_q;
  assign ErrorDireccion = error_q;
  assign Ocupado        = (estado_q != LISTO);

endmodule

// File: tb/tb_memoria_parametrizada.sv
// Bench for the parametrised memory: a 16x16 and a 32x10 instance driven side by side.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: init busy window is tracked by the reference model.
module tb_memoria_parametrizada;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, re;
  logic [15:0] dir;
  logic [31:0] ent;

  logic [15:0] sal_a;
  logic        val_a, ocu_a, err_a;
  logic [31:0] sal_b;
  logic        val_b, ocu_b, err_b;

  memoria_parametrizada #(
    .ANCHO_DATOS(16), .PROFUNDIDAD(16), .ANCHO_DIRECCION(16),
    .ARRANQUE0(16'h4000), .ARRANQUE1(16'h0017)
  ) u_a (
    .Reloj(clk), .Reinicio(rst), .Entrada(ent[15:0]), .Direccion(dir),
    .HabilitarEscritura(we), .HabilitarSalida(re),
    .Salida(sal_a), .SalidaValida(val_a), .Ocupado(ocu_a), .ErrorDireccion(err_a)
  );

  memoria_parametrizada #(
    .ANCHO_DATOS(32), .PROFUNDIDAD(10), .ANCHO_DIRECCION(16),
    .ARRANQUE0(16'h4000), .ARRANQUE1(16'h0017)
  ) u_b (
    .Reloj(clk), .Reinicio(rst), .Entrada(ent), .Direccion(dir),
    .HabilitarEscritura(we), .HabilitarSalida(re),
    .Salida(sal_b), .SalidaValida(val_b), .Ocupado(ocu_b), .ErrorDireccion(err_b)
  );

  // Reference model: one entry per instance (0 = 16x16, 1 = 32x10).
  int          prof    [2] = '{16, 10};
  logic [31:0] mascara [2] = '{32'h0000FFFF, 32'hFFFFFFFF};
  logic [31:0] mm      [2][16];
  logic [31:0] ult     [2];
  int          resta   [2];
  logic        ev      [2];
  logic        ee      [2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nombre, act, exp);
    end
  endtask

  task automatic modelo_flanco(input logic r, input logic w, input logic l,
                               input logic [15:0] a, input logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b0;
      ee[k] = 1'b0;
      if (r) begin
        resta[k] = prof[k] + 2;
        for (int i = 0; i < 16; i++) mm[k][i] = '0;
        mm[k][0] = 32'h4000;
        mm[k][1] = 32'h0017;
        ult[k]   = '0;
      end else if (resta[k] > 0) begin
        resta[k]--;
      end else if (w) begin
        if (int'(a) < prof[k]) mm[k][a] = d & mascara[k];
        else ee[k] = 1'b1;
      end else if (l) begin
        ev[k] = 1'b1;
        if (int'(a) < prof[k]) begin
          ult[k] = mm[k][a];
        end else begin
          ult[k] = '0;
          ee[k]  = 1'b1;
        end
      end
    end
  endtask

  task automatic comparar();
    chk("A.Salida",         {16'h0, sal_a}, ult[0]);
    chk("A.SalidaValida",   val_a, ev[0]);
    chk("A.ErrorDireccion", err_a, ee[0]);
    chk("A.Ocupado",        ocu_a, resta[0] > 0);
    chk("B.Salida",         sal_b, ult[1]);
    chk("B.SalidaValida",   val_b, ev[1]);
    chk("B.ErrorDireccion", err_b, ee[1]);
    chk("B.Ocupado",        ocu_b, resta[1] > 0);
  endtask

  task automatic ciclo(input logic r, input logic w, input logic l,
                       input logic [15:0] a, input logic [31:0] d);
    rst = r; we = w; re = l; dir = a; ent = d;
    @(posedge clk);
    modelo_flanco(r, w, l, a, d);
    #1;
    comparar();
  endtask

  // Releases reset, counts edges until each instance drops Ocupado; optional busy-time write.
  task automatic esperar_init(input logic con_peticion, output int caida_a, output int caida_b);
    caida_a = 0;
    caida_b = 0;
    for (int n = 1; n <= 40; n++) begin
      if (con_peticion && n <= 5) begin
        ciclo(1'b0, 1'b1, 1'b1, 16'd2, 32'hFFFFFFFF);
        chk("ocupado_sin_valida", {30'h0, val_a, val_b}, 32'h0);
        chk("ocupado_sin_error",  {30'h0, err_a, err_b}, 32'h0);
      end else begin
        ciclo(1'b0, 1'b0, 1'b0, 16'd0, 32'h0);
      end
      if (!ocu_a && caida_a == 0) caida_a = n;
      if (!ocu_b && caida_b == 0) caida_b = n;
      if (caida_a != 0 && caida_b != 0) break;
    end
  endtask

  typedef struct {
    logic        w;
    logic        l;
    logic [15:0] a;
    logic [31:0] d;
    logic [15:0] s;
    logic        v;
    logic        e;
  } vec_t;

  vec_t tabla [14];

  initial begin
    int ca, cb;
    logic r, w, l;
    logic [15:0] a;

    tabla[0]  = '{1'b0, 1'b1, 16'h0000, 32'h0,        16'h4000, 1'b1, 1'b0};
    tabla[1]  = '{1'b0, 1'b1, 16'h0001, 32'h0,        16'h0017, 1'b1, 1'b0};
    tabla[2]  = '{1'b0, 1'b1, 16'h0002, 32'h0,        16'h0000, 1'b1, 1'b0};
    tabla[3]  = '{1'b1, 1'b0, 16'h0005, 32'h0000BEEF, 16'h0000, 1'b0, 1'b0};
    tabla[4]  = '{1'b0, 1'b1, 16'h0005, 32'h0,        16'hBEEF, 1'b1, 1'b0};
    tabla[5]  = '{1'b0, 1'b1, 16'h0010, 32'h0,        16'h0000, 1'b1, 1'b1};
    tabla[6]  = '{1'b1, 1'b0, 16'h0010, 32'h0000FFFF, 16'h0000, 1'b0, 1'b1};
    tabla[7]  = '{1'b0, 1'b1, 16'h0000, 32'h0,        16'h4000, 1'b1, 1'b0};
    tabla[8]  = '{1'b1, 1'b1, 16'h0003, 32'h00001234, 16'h4000, 1'b0, 1'b0};
    tabla[9]  = '{1'b0, 1'b1, 16'h0003, 32'h0,        16'h1234, 1'b1, 1'b0};
    tabla[10] = '{1'b0, 1'b0, 16'h0003, 32'h0,        16'h1234, 1'b0, 1'b0};
    tabla[11] = '{1'b0, 1'b1, 16'hFFFF, 32'h0,        16'h0000, 1'b1, 1'b1};
    tabla[12] = '{1'b1, 1'b0, 16'h0013, 32'h00005555, 16'h0000, 1'b0, 1'b1};
    tabla[13] = '{1'b0, 1'b1, 16'h0003, 32'h0,        16'h1234, 1'b1, 1'b0};

    rst = 1'b1; we = 1'b0; re = 1'b0; dir = '0; ent = '0;
    for (int k = 0; k < 2; k++) begin
      resta[k] = 0; ult[k] = '0; ev[k] = 1'b0; ee[k] = 1'b0;
    end

    // Reset, then a write to address 2 while busy that must be ignored.
    ciclo(1'b1, 1'b0, 1'b0, 16'd0, 32'h0);
    ciclo(1'b1, 1'b0, 1'b0, 16'd0, 32'h0);
    chk("reset.Salida_A", {16'h0, sal_a}, 32'h0);
    chk("reset.Ocupado_A", ocu_a, 1'b1);
    esperar_init(1'b1, ca, cb);
    chk("init_ciclos_A", ca, 18);
    chk("init_ciclos_B", cb, 12);

    // Directed table against the 16x16 instance.
    for (int i = 0; i < 14; i++) begin
      ciclo(1'b0, tabla[i].w, tabla[i].l, tabla[i].a, tabla[i].d);
      chk($sformatf("tabla%0d.Salida", i),         {16'h0, sal_a}, {16'h0, tabla[i].s});
      chk($sformatf("tabla%0d.SalidaValida", i),   val_a, tabla[i].v);
      chk($sformatf("tabla%0d.ErrorDireccion", i), err_a, tabla[i].e);
    end

    // 32x10 instance: last valid word and first invalid one.
    ciclo(1'b0, 1'b1, 1'b0, 16'd9, 32'hCAFEF00D);
    ciclo(1'b0, 1'b0, 1'b1, 16'd9, 32'h0);
    chk("B.lee9.Salida", sal_b, 32'hCAFEF00D);
    chk("B.lee9.Valida", val_b, 1'b1);
    chk("B.lee9.Error",  err_b, 1'b0);
    ciclo(1'b0, 1'b0, 1'b1, 16'd10, 32'h0);
    chk("B.lee10.Salida", sal_b, 32'h0);
    chk("B.lee10.Valida", val_b, 1'b1);
    chk("B.lee10.Error",  err_b, 1'b1);

    // Reset again at clear cycle 7 of a rerun; the whole sequence must restart.
    ciclo(1'b0, 1'b1, 1'b0, 16'd5, 32'h0000BEEF);
    ciclo(1'b1, 1'b0, 1'b0, 16'd0, 32'h0);
    for (int n = 0; n < 7; n++) ciclo(1'b0, 1'b0, 1'b0, 16'd0, 32'h0);
    ciclo(1'b1, 1'b0, 1'b0, 16'd0, 32'h0);
    chk("reinicio_medio.Ocupado", ocu_a, 1'b1);
    esperar_init(1'b0, ca, cb);
    chk("reinicio_medio.ciclos_A", ca, 18);
    ciclo(1'b0, 1'b0, 1'b1, 16'd5, 32'h0);
    chk("reinicio_medio.lee5", {16'h0, sal_a}, 32'h0);
    ciclo(1'b0, 1'b0, 1'b1, 16'd0, 32'h0);
    chk("reinicio_medio.lee0", {16'h0, sal_a}, 32'h4000);

    // Randomised traffic, including occasional resets, against the model.
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 199) == 0);
      w = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 1) == 1);
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 19));
      ciclo(r, w, l, a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
